// File: rtl/uart_pkg.sv
// Shared UART definitions: oversample ratio encodings, divisor width defaults
// and the reset-divisor computation used by the baud generator.
package uart_pkg;

  typedef enum logic {
    OS_16X = 1'b0,
    OS_8X  = 1'b1
  } os_sel_e;

  localparam int DIV_INT_W_DEF  = 16;
  localparam int DIV_FRAC_W_DEF = 4;

  // Fixed-point divisor, rounded to nearest, for 16x oversampling.
  function automatic longint unsigned default_div(
    input longint unsigned clk_freq,
    input longint unsigned baud,
    input int unsigned     frac_w
  );
    longint unsigned num;
    longint unsigned den;
    num = clk_freq << frac_w;
    den = 64'd16 * baud;
    return (num + (den >> 1)) / den;
  endfunction

endpackage

// File: rtl/baud_frac_accum.sv
// Fractional phase accumulator: adds the fractional divisor once per
// oversample period and reports the carry that stretches the period by one.
module baud_frac_accum #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         step,
  input  logic [W-1:0] frac,
  output logic         carry
);

  logic [W-1:0] acc;
  logic [W-1:0] base;
  logic [W:0]   sum;

  // clear takes effect combinationally so the period being timed already
  // sees a zeroed accumulator.
  assign base  = clear ? '0 : acc;
  assign sum   = {1'b0, base} + {1'b0, frac};
  assign carry = sum[W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (step) begin
      acc <= sum[W-1:0];
    end else if (clear) begin
      acc <= '0;
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: oversample and bit strobes from an
// integer+fraction divisor, with shadowed divisor updates on bit boundaries.
module baud_gen_frac
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned DEFAULT_BAUD = 9600,
  parameter int          DIV_INT_W    = DIV_INT_W_DEF,
  parameter int          DIV_FRAC_W   = DIV_FRAC_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DIV_INT_W-1:0]  div_int,
  input  logic [DIV_FRAC_W-1:0] div_frac,
  input  logic                  os_sel,
  input  logic                  div_load,
  output logic                  os_tick,
  output logic                  baud_tick,
  output logic                  load_pending
);

  localparam longint unsigned DEF_D =
    default_div(64'(CLK_FREQ), 64'(DEFAULT_BAUD), DIV_FRAC_W);
  localparam logic [DIV_INT_W-1:0]  DEF_INT  = DIV_INT_W'(DEF_D >> DIV_FRAC_W);
  localparam logic [DIV_FRAC_W-1:0] DEF_FRAC = DIV_FRAC_W'(DEF_D);

  logic [DIV_INT_W-1:0]  act_int, sh_int, use_int, eff_int;
  logic [DIV_FRAC_W-1:0] act_frac, sh_frac, use_frac;
  os_sel_e               act_os, sh_os, use_os;
  logic [DIV_INT_W:0]    cnt, cnt_base, period, term_cnt;
  logic [3:0]            os_cnt, os_base, os_last;
  logic                  apply, carry, term, os_wrap, acc_clear;

  // The apply edge times the first new period itself, so a divisor change
  // neither stretches nor truncates the bit that follows the boundary.
  assign apply     = load_pending && (baud_tick || !en);
  assign use_int   = apply ? sh_int : act_int;
  assign use_frac  = apply ? sh_frac : act_frac;
  assign use_os    = apply ? sh_os : act_os;
  assign eff_int   = (use_int == '0) ? DIV_INT_W'(1) : use_int;
  assign cnt_base  = apply ? '0 : cnt;
  assign os_base   = apply ? '0 : os_cnt;
  assign os_last   = (use_os == OS_8X) ? 4'd7 : 4'd15;
  assign acc_clear = apply || !en;

  baud_frac_accum #(
    .W(DIV_FRAC_W)
  ) u_accum (
    .clk   (clk),
    .reset (reset),
    .clear (acc_clear),
    .step  (term),
    .frac  (use_frac),
    .carry (carry)
  );

  assign period   = {1'b0, eff_int} + {{DIV_INT_W{1'b0}}, carry};
  assign term_cnt = period - (DIV_INT_W+1)'(1);
  assign term     = en && (cnt_base == term_cnt);
  assign os_wrap  = term && (os_base == os_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_int      <= DEF_INT;
      act_frac     <= DEF_FRAC;
      act_os       <= OS_16X;
      sh_int       <= DEF_INT;
      sh_frac      <= DEF_FRAC;
      sh_os        <= OS_16X;
      load_pending <= 1'b0;
      cnt          <= '0;
      os_cnt       <= '0;
      os_tick      <= 1'b0;
      baud_tick    <= 1'b0;
    end else begin
      // A load landing on the apply edge refills the shadow and stays pending.
      if (div_load) begin
        sh_int       <= div_int;
        sh_frac      <= div_frac;
        sh_os        <= os_sel_e'(os_sel);
        load_pending <= 1'b1;
      end else if (apply) begin
        load_pending <= 1'b0;
      end

      if (apply) begin
        act_int  <= sh_int;
        act_frac <= sh_frac;
        act_os   <= sh_os;
      end

      if (!en) begin
        cnt       <= '0;
        os_cnt    <= '0;
        os_tick   <= 1'b0;
        baud_tick <= 1'b0;
      end else if (term) begin
        cnt       <= '0;
        os_cnt    <= os_wrap ? 4'd0 : os_base + 4'd1;
        os_tick   <= 1'b1;
        baud_tick <= os_wrap;
      end else begin
        cnt       <= cnt_base + (DIV_INT_W+1)'(1);
        os_cnt    <= os_base;
        os_tick   <= 1'b0;
        baud_tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: per-cycle strobe/pending checks
// against a closed-form tick schedule T_n = n*eff + floor(n*frac/16).
module tb_baud_gen_frac;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic        os_sel = 1'b0;
  logic        div_load = 1'b0;
  logic        os_tick, baud_tick, load_pending;

  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: next expected os tick index and its cycle.
  int   m_eff, m_frac, m_os, m_n, m_next, m_t;
  logic exp_pend = 1'b0;
  logic last_os, last_baud;

  baud_gen_frac dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .div_int      (div_int),
    .div_frac     (div_frac),
    .os_sel       (os_sel),
    .div_load     (div_load),
    .os_tick      (os_tick),
    .baud_tick    (baud_tick),
    .load_pending (load_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: {os,baud,pend} observed=%b expected=%b at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_start(input int iv, input int fv, input int osx);
    m_eff  = (iv == 0) ? 1 : iv;
    m_frac = fv;
    m_os   = osx ? 8 : 16;
    m_n    = 1;
    m_next = m_eff + (m_frac >> 4);
    m_t    = 0;
  endtask

  // Called just after a negedge that follows an enabled rising edge.
  task automatic step_check(input string tag);
    logic eo, eb;
    m_t++;
    eo = (m_t == m_next);
    eb = eo && ((m_n % m_os) == 0);
    if (eo) begin
      m_n++;
      m_next = m_n * m_eff + ((m_n * m_frac) >> 4);
    end
    last_os   = eo;
    last_baud = eb;
    check(tag, {os_tick, baud_tick, load_pending}, {eo, eb, exp_pend});
  endtask

  task automatic run(input string tag, input int ncyc);
    repeat (ncyc) begin
      @(negedge clk);
      step_check(tag);
    end
  endtask

  // Load while disabled: capture on the first edge, apply on the second.
  task automatic load_cfg(input int iv, input int fv, input int osx);
    en       = 1'b0;
    div_int  = 16'(iv);
    div_frac = 4'(fv);
    os_sel   = (osx != 0);
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    check("load_capture", {os_tick, baud_tick, load_pending}, 3'b001);
    @(negedge clk);
    check("load_apply", {os_tick, baud_tick, load_pending}, 3'b000);
  endtask

  initial begin
    int iv, fv, ox;
    logic found;

    repeat (3) @(negedge clk);
    check("reset_state", {os_tick, baud_tick, load_pending}, 3'b000);
    reset = 1'b0;
    @(negedge clk);

    // Reset divisor 651 + 1/16: fifteen 651-cycle periods then one of 652.
    en = 1'b1;
    model_start(651, 1, 0);
    run("default", 2 * 10417 + 4);

    load_cfg(4, 8, 0);
    en = 1'b1;
    model_start(4, 8, 0);
    run("alt_4_8", 3 * 72 + 2);

    load_cfg(3, 0, 1);
    en = 1'b1;
    model_start(3, 0, 1);
    run("os8x", 3 * 24 + 2);

    load_cfg(0, 0, 0);
    en = 1'b1;
    model_start(0, 0, 0);
    run("zero_div", 3 * 16 + 2);

    for (int r = 0; r < 6; r++) begin
      iv = int'($urandom_range(0, 12));
      fv = int'($urandom_range(0, 15));
      ox = int'($urandom_range(0, 1));
      load_cfg(iv, fv, ox);
      en = 1'b1;
      model_start(iv, fv, ox);
      run("random", (ox != 0 ? 8 : 16) * (iv + 2) * 2 + 3);
    end

    // Two loads inside one bit: old timing holds, the second load wins.
    load_cfg(5, 3, 0);
    en = 1'b1;
    model_start(5, 3, 0);
    for (int c = 1; c <= 83 + 3 * 26 + 2; c++) begin
      @(negedge clk);
      step_check("midbit");
      if (last_baud && exp_pend) begin
        model_start(3, 5, 1);
        exp_pend = 1'b0;
      end
      div_load = 1'b0;
      if (c == 20) begin
        div_int = 16'd2; div_frac = 4'd0; os_sel = 1'b0; div_load = 1'b1;
        exp_pend = 1'b1;
      end
      if (c == 40) begin
        div_int = 16'd3; div_frac = 4'd5; os_sel = 1'b1; div_load = 1'b1;
      end
    end

    en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("en_off", {os_tick, baud_tick, load_pending}, 3'b000);
    end
    en = 1'b1;
    model_start(3, 5, 1);
    run("en_restart", 60);

    // Reset during an os_tick with a load pending: everything drops at once.
    load_cfg(4, 8, 0);
    en = 1'b1;
    model_start(4, 8, 0);
    found = 1'b0;
    for (int c = 1; c <= 60 && !found; c++) begin
      @(negedge clk);
      step_check("pre_reset");
      div_load = 1'b0;
      if (c == 10) begin
        div_int = 16'd7; div_frac = 4'd0; os_sel = 1'b1; div_load = 1'b1;
        exp_pend = 1'b1;
      end
      if (c >= 30 && last_os) found = 1'b1;
    end
    #1 reset = 1'b1;
    #1 check("reset_async", {os_tick, baud_tick, load_pending}, 3'b000);
    en = 1'b0;
    div_load = 1'b0;
    exp_pend = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    en = 1'b1;
    model_start(651, 1, 0);
    run("post_reset", 1400);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/baud_gen_frac.md
# baud_gen_frac

Runtime-programmable fractional baud-rate generator for the UART datapath. It produces a 1-cycle oversample strobe (`os_tick`) for the RX sampler and a 1-cycle bit strobe (`baud_tick`) for the TX shifter. The divisor has an integer part and a fractional part, and the oversample ratio is selectable. Divisor changes are applied glitch-free on a bit boundary, so an APB register write never produces a truncated or stretched bit.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock in Hz, used only for the reset divisor.
- `DEFAULT_BAUD`, default 9600: baud rate loaded at reset, with 16x oversampling.
- `DIV_INT_W`, default 16: width of the integer divisor.
- `DIV_FRAC_W`, default 4: width of the fractional divisor, in units of 1/2^DIV_FRAC_W.
- `clk` input, 1 bit: clock.
- `reset` input, 1 bit: asynchronous, active-high.
- `en` input, 1 bit: generator enable.
- `div_int` input, DIV_INT_W bits: requested integer divisor, in clk cycles per os_tick.
- `div_frac` input, DIV_FRAC_W bits: requested fractional divisor.
- `os_sel` input, 1 bit: requested oversample ratio; 0 = 16x, 1 = 8x.
- `div_load` input, 1 bit: pulse that captures div_int, div_frac and os_sel into the shadow registers.
- `os_tick` output, 1 bit: oversample strobe, 1 cycle wide.
- `baud_tick` output, 1 bit: bit strobe, coincident with every OS-th os_tick.
- `load_pending` output, 1 bit: a captured divisor is waiting to be applied.

## Operation
- Active divisor registers: `act_int`, `act_frac`, `act_os`, where OS = 16 or 8.
- At reset these registers are loaded with the defaults:
  - D = round(CLK_FREQ·2^DIV_FRAC_W / (16·DEFAULT_BAUD))
  - act_int = D >> DIV_FRAC_W
  - act_frac = D mod 2^DIV_FRAC_W
  - act_os = 16x
- Fractional accumulator `acc` (DIV_FRAC_W bits, 0 after reset) updates once per os period k:
  - {c_k, acc_{k+1}} = acc_k + act_frac
  - length of period k is P_k = eff_int + c_k
  - eff_int = max(act_int, 1); a divisor of 0 is treated as 1.
- Cycle counter: DIV_INT_W+1 bits, counts 0..P_k−1. os_tick is asserted on the terminal count and the counter wraps to 0.
- OS counter (4 bits) counts os_ticks 0..OS−1. baud_tick is asserted together with the os_tick on which the OS counter wraps.
- Shadow load:
  - A div_load pulse captures the three inputs into the shadow registers and sets load_pending.
  - The shadow is copied into the active registers in the cycle after the next baud_tick. That copy also clears acc, the cycle counter, the OS counter and load_pending.
- div_load while load_pending=1: the shadow is overwritten and pending stays set; last write wins.
- div_load in the same cycle as a baud_tick: the load is captured but is not applied at that boundary. It waits for the following baud_tick.
- en=0:
  - cycle counter, OS counter and acc are held at 0
  - os_tick and baud_tick are 0
  - any pending shadow is applied on the next clock edge.
- en=1 after en=0: the first os_tick comes P_0 cycles later.
- Reset asserted mid-operation: all state returns to reset values immediately, and the shadow contents are discarded.

## Timing
- All outputs are registered.
- Reset values: os_tick=0, baud_tick=0, load_pending=0.
- os_tick is high for exactly 1 cycle. When eff_int=1 and act_frac=0 it is high continuously.
- Consecutive os_ticks are P_k cycles apart. The first os_tick is asserted P_0 cycles after the first rising edge at which en=1 is sampled.
- Baud period = OS·act_int + floor(OS·act_frac / 2^DIV_FRAC_W) cycles, exact for OS a multiple of 2^DIV_FRAC_W / gcd. With the defaults (OS=16, DIV_FRAC_W=4) it is exactly 16·act_int + act_frac.
- load_pending rises in the cycle after div_load and falls in the same cycle the new divisor becomes active.

## Structure
- Shared package `uart_pkg`:
  - OS_16X / OS_8X encodings
  - DIV_INT_W / DIV_FRAC_W defaults
  - a function computing the default divisor from CLK_FREQ and BAUD
- Sub-module `baud_frac_accum`: the acc register plus the carry adder, with a clear input and a step input. It outputs carry.
- Top level holds the cycle counter, OS counter, shadow/active registers and output registers.

## Test plan
- **Reset default.** Defaults, en=1: act_int=651, act_frac=1. Expect 15 os periods of 651 cycles then one of 652, and baud_tick every 10417 cycles.
- **Alternating periods.** Load div_int=4, div_frac=8, 16x, en toggled low then high. Expect os periods 4,5,4,5…, baud period 72, baud_tick on the 16th os_tick.
- **8x mode.** div_int=3, div_frac=0, os_sel=1. Expect os_tick every 3 cycles and baud_tick every 24 cycles.
- **Mid-bit load.** div_load mid-bit, then a second div_load before the boundary. Expect the old period retained until baud_tick, load_pending=1 throughout, and only the second value taking effect after that baud_tick.
- **Zero divisor.** div_int=0, div_frac=0. Expect os_tick high every cycle and baud_tick every 16 cycles.
- **Reset and enable.** Reset asserted mid-bit: all outputs 0 immediately, and the default divisor is restored. en=0 for 5 cycles: no ticks, counters restart from 0.
